ristretto_fetch_sequencer: RTL and testbench
============================================

Name: ristretto_fetch_sequencer

Overview:
- Sequences the instruction-memory port on behalf of the prefetch buffer.
- Generates sequential fetch addresses and issues req/gnt transactions, with at most MaxOutstanding in flight.
- Tracks in-flight responses; after a control/trap redirect, stale responses are counted and discarded.
- Presents the prefetch-buffer side contract:
  - new_instr pulse with instruction;
  - current PC = instruction address + 4;
  - busy.

Parameters:
DataWidth, 32, instruction/data bus width
AddrWidth, 32, address width
MaxOutstanding, 2, maximum issued-but-unanswered transactions (1..4)
BootAddr, 32'h0000_0080, first fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  reset; one clock; reset is asynchronous and active-low
fs_fetch_en_i  in  1  core allows fetching; 0 = no new requests issued
fs_fetch_req_i  in  1  prefetch buffer requests one instruction (driven by buffer fu_fetch)
fs_redirect_i  in  1  one-cycle pulse: jump/trap redirect
fs_redirect_pc_i  in  AddrWidth  redirect target, word aligned
fs_new_instr_o  out  1  one-cycle valid pulse for fs_instr_o
fs_instr_o  out  DataWidth  fetched instruction
fs_current_pc_o  out  AddrWidth  address of delivered instruction + 4
fs_busy_o  out  1  cannot accept fs_fetch_req_i this cycle
fs_imem_req_o  out  1  memory request
fs_imem_addr_o  out  AddrWidth  request address
fs_imem_gnt_i  in  1  request accepted
fs_imem_rvalid_i  in  1  response valid (in order)
fs_imem_rdata_i  in  DataWidth  response data

Behaviour:
- Reset values (asynchronous, active-low):
  - outputs: fs_imem_req_o=0, fs_new_instr_o=0, fs_busy_o=0, fs_instr_o=0.
  - fs_imem_addr_o=BootAddr; fs_current_pc_o=BootAddr.
  - state: FSM=IDLE; outstanding_cnt=0; drop_cnt=0; next_pc=BootAddr; resp_pc=BootAddr.
- FSM states:
  - IDLE: req=0.
    - To ISSUE when fs_fetch_en_i & fs_fetch_req_i & outstanding_cnt<MaxOutstanding.
    - Registered transition: req rises on the next cycle, addr=next_pc.
  - ISSUE: req=1, addr held stable until gnt (addr never changes while req=1 without gnt).
    - On gnt: outstanding_cnt+1 and next_pc+=4.
    - Then to IDLE, or stay in ISSUE (back-to-back) if fetch_req & fetch_en & cnt+1<MaxOutstanding.
  - WAIT: entered when outstanding_cnt==MaxOutstanding after a grant; to IDLE on first rvalid.
- Responses:
  - rvalid decrements outstanding_cnt; simultaneous gnt+rvalid leaves it unchanged.
  - If drop_cnt==0: fs_new_instr_o=1 registered, one cycle after rvalid; fs_instr_o=rdata; fs_current_pc_o=resp_pc+4; resp_pc+=4.
  - If drop_cnt>0: response is discarded, drop_cnt-1, no pulse, resp_pc unchanged.
- fs_busy_o = (state==ISSUE & ~gnt) | outstanding_cnt==MaxOutstanding | drop_cnt!=0 | ~fs_fetch_en_i.
- Redirect (fs_redirect_i=1):
  - next_pc and resp_pc take fs_redirect_pc_i.
  - drop_cnt = outstanding_cnt − (rvalid that cycle) + (ISSUE & ~gnt ? 1 : 0) + (gnt that cycle).
  - A pending un-granted request is not retracted: it completes and its response is dropped.
  - A response arriving in the redirect cycle is also dropped; fs_new_instr_o is suppressed in the following cycle.
  - After drop_cnt reaches 0, fetching resumes from the redirect target.
- Redirect while drop_cnt>0: recompute drop_cnt as above (stale responses of both generations dropped); latest target wins.
- Arithmetic:
  - PC increments are modulo 2^AddrWidth; wrap from all-ones-minus-3 to 0 is legal.
  - Counters are $clog2(MaxOutstanding+1) bits; they never overflow by construction.
- fs_fetch_en_i deasserted mid-ISSUE: request held until gnt (protocol rule); no further requests.
- Error: rvalid with outstanding_cnt==0 and drop_cnt==0 is illegal; assertion fires in simulation.

Optional Feature:
RISTRETTO_FS_IMEM_ERR_EN
- With it:
  - adds input fs_imem_err_i (1) and output fs_fetch_err_o (1).
  - Non-dropped rvalid with err=1: fs_new_instr_o=1, fs_instr_o=32'h0000_0013 (NOP), fs_fetch_err_o=1 for that cycle.
  - fetching then stops (busy=1) until the next fs_redirect_i.
- Without it: port absent; all responses treated as good.

Test Plan:
1. Reset release, fetch_en=1, fetch_req=1, gnt tied 1, rvalid 1 cycle after gnt:
   - addresses issued 0x80, 0x84, 0x88.
   - new_instr pulses carry current_pc 0x84, 0x88, 0x8C.
2. Back-pressure: gnt low 3 cycles with req=1:
   - addr stays 0x80 and busy=1 for all three cycles.
   - on gnt, next address 0x84.
3. MaxOutstanding=2, rvalid withheld:
   - exactly 2 grants; busy=1; no third req.
   - first rvalid releases it; the next request carries 0x88.
4. Redirect to 0x200 with 2 outstanding:
   - drop_cnt=2; both responses produce no new_instr.
   - next request addr 0x200; first delivered current_pc=0x204.
5. Redirect in the same cycle as gnt+rvalid, with a second redirect to 0x300 while draining:
   - all stale data dropped.
   - next address 0x300; no spurious new_instr.
6. RISTRETTO_FS_IMEM_ERR_EN defined, err=1 on response to 0x84:
   - new_instr with instr 0x13 and fetch_err=1.
   - no requests issued until redirect to 0x400, then fetch resumes at 0x400.

Source files
------------

// File: rtl/ristretto_fetch_sequencer_if.sv
// Instruction-memory req/gnt bus: sequencer is master, memory is slave.
// Error return (fs_imem_err) exists only when RISTRETTO_FS_IMEM_ERR_EN is defined.
interface ristretto_fetch_sequencer_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic                 fs_imem_req;
  logic [AddrWidth-1:0] fs_imem_addr;
  logic                 fs_imem_gnt;
  logic                 fs_imem_rvalid;
  logic [DataWidth-1:0] fs_imem_rdata;
`ifdef RISTRETTO_FS_IMEM_ERR_EN
  logic                 fs_imem_err;

  modport master (output fs_imem_req, fs_imem_addr,
                  input  fs_imem_gnt, fs_imem_rvalid, fs_imem_rdata, fs_imem_err);
  modport slave  (input  fs_imem_req, fs_imem_addr,
                  output fs_imem_gnt, fs_imem_rvalid, fs_imem_rdata, fs_imem_err);
`else
  modport master (output fs_imem_req, fs_imem_addr,
                  input  fs_imem_gnt, fs_imem_rvalid, fs_imem_rdata);
  modport slave  (input  fs_imem_req, fs_imem_addr,
                  output fs_imem_gnt, fs_imem_rvalid, fs_imem_rdata);
`endif
endinterface

// File: rtl/ristretto_fetch_sequencer.sv
// Instruction fetch sequencer: issues sequential req/gnt fetches, drops stale responses after redirect.
// Define RISTRETTO_FS_IMEM_ERR_EN to add the memory error return and fs_fetch_err_o.
module ristretto_fetch_sequencer #(
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          MaxOutstanding = 2,
  parameter logic [AddrWidth-1:0] BootAddr       = AddrWidth'(32'h0000_0080)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 fs_fetch_en_i,
  input  logic                 fs_fetch_req_i,
  input  logic                 fs_redirect_i,
  input  logic [AddrWidth-1:0] fs_redirect_pc_i,
  output logic                 fs_new_instr_o,
  output logic [DataWidth-1:0] fs_instr_o,
  output logic [AddrWidth-1:0] fs_current_pc_o,
  output logic                 fs_busy_o,
`ifdef RISTRETTO_FS_IMEM_ERR_EN
  output logic                 fs_fetch_err_o,
`endif
  ristretto_fetch_sequencer_if.master imem
);
  localparam int unsigned          CntW   = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0]      MaxCnt = CntW'(MaxOutstanding);
  localparam logic [DataWidth-1:0] Nop    = DataWidth'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      out_cnt_q, out_cnt_d, out_cnt_inc;
  logic [CntW-1:0]      drop_cnt_q, drop_cnt_d;
  logic [AddrWidth-1:0] next_pc_q, next_pc_d, addr_q, addr_d, resp_pc_q, cur_pc_q;
  logic [DataWidth-1:0] instr_q;
  logic                 new_instr_q, err_stop_q, err_stop_d;
  logic                 gnt_acc, rvalid, resp_err, deliver, err_hit, issue_ok;

  assign gnt_acc = (state_q == ISSUE) & imem.fs_imem_gnt;
  assign rvalid  = imem.fs_imem_rvalid;
`ifdef RISTRETTO_FS_IMEM_ERR_EN
  assign resp_err = imem.fs_imem_err;
`else
  assign resp_err = 1'b0;
`endif
  // Responses landing in the redirect cycle belong to the old stream and are dropped.
  assign deliver     = rvalid & (drop_cnt_q == '0) & ~fs_redirect_i;
  assign err_hit     = deliver & resp_err;
  assign err_stop_d  = fs_redirect_i ? 1'b0 : (err_stop_q | err_hit);
  assign out_cnt_inc = out_cnt_q + 1'b1;
  // No new request while redirecting, draining stale data or halted on a bus error.
  assign issue_ok = fs_fetch_en_i & fs_fetch_req_i & ~fs_redirect_i & (drop_cnt_q == '0)
                  & ~err_stop_q & ~err_hit;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    next_pc_d  = next_pc_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + CntW'(gnt_acc) - CntW'(rvalid);
    if (gnt_acc) next_pc_d = next_pc_q + AddrWidth'(4);
    unique case (state_q)
      IDLE: begin
        if (issue_ok && out_cnt_q < MaxCnt) begin
          state_d = ISSUE;
          addr_d  = next_pc_q;
        end
      end
      ISSUE: begin
        // Address is frozen until the grant; only then may it advance.
        if (gnt_acc) begin
          if (issue_ok && out_cnt_inc < MaxCnt) begin
            state_d = ISSUE;
            addr_d  = next_pc_q + AddrWidth'(4);
          end else if (out_cnt_d == MaxCnt) begin
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT: begin
        if (rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every transaction still owed by memory, including one being granted now, is stale.
    if (fs_redirect_i) begin
      next_pc_d  = fs_redirect_pc_i;
      drop_cnt_d = out_cnt_q - CntW'(rvalid) + CntW'(state_q == ISSUE);
    end else if (rvalid && drop_cnt_q != '0) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      out_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      next_pc_q   <= BootAddr;
      addr_q      <= BootAddr;
      resp_pc_q   <= BootAddr;
      cur_pc_q    <= BootAddr;
      instr_q     <= '0;
      new_instr_q <= 1'b0;
      err_stop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      next_pc_q   <= next_pc_d;
      addr_q      <= addr_d;
      new_instr_q <= deliver;
      err_stop_q  <= err_stop_d;
      if (fs_redirect_i)  resp_pc_q <= fs_redirect_pc_i;
      else if (deliver)   resp_pc_q <= resp_pc_q + AddrWidth'(4);
      if (deliver) begin
        instr_q  <= err_hit ? Nop : imem.fs_imem_rdata;
        cur_pc_q <= resp_pc_q + AddrWidth'(4);
      end
    end
  end

`ifdef RISTRETTO_FS_IMEM_ERR_EN
  logic fetch_err_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) fetch_err_q <= 1'b0;
    else         fetch_err_q <= err_hit;
  end
  assign fs_fetch_err_o = fetch_err_q;
`endif

  assign imem.fs_imem_req  = (state_q == ISSUE);
  assign imem.fs_imem_addr = addr_q;
  assign fs_new_instr_o    = new_instr_q;
  assign fs_instr_o        = instr_q;
  assign fs_current_pc_o   = cur_pc_q;
  assign fs_busy_o = ((state_q == ISSUE) & ~imem.fs_imem_gnt) | (out_cnt_q == MaxCnt)
                   | (drop_cnt_q != '0) | ~fs_fetch_en_i | err_stop_q;

`ifndef SYNTHESIS
  rvalid_legal_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
    rvalid |-> (out_cnt_q != '0 || drop_cnt_q != '0));
`endif
endmodule

// File: tb/tb_ristretto_fetch_sequencer.sv
// Directed bench for ristretto_fetch_sequencer: memory model + grant/delivery scoreboards.
// Test 6 is compiled only with RISTRETTO_FS_IMEM_ERR_EN.
module tb_ristretto_fetch_sequencer;
  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        fetch_en = 1'b1, fetch_req = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        new_instr, busy;
  logic [31:0] instr, current_pc;
`ifdef RISTRETTO_FS_IMEM_ERR_EN
  logic        fetch_err;
`endif

  always #5 clk_i = ~clk_i;

  ristretto_fetch_sequencer_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  ristretto_fetch_sequencer #(.DataWidth(32), .AddrWidth(32), .MaxOutstanding(2),
                              .BootAddr(32'h0000_0080)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .fs_fetch_en_i(fetch_en), .fs_fetch_req_i(fetch_req),
    .fs_redirect_i(redirect), .fs_redirect_pc_i(redirect_pc),
    .fs_new_instr_o(new_instr), .fs_instr_o(instr),
    .fs_current_pc_o(current_pc), .fs_busy_o(busy),
`ifdef RISTRETTO_FS_IMEM_ERR_EN
    .fs_fetch_err_o(fetch_err),
`endif
    .imem(bus)
  );

  typedef struct packed {logic [31:0] instr; logic [31:0] pc; logic err;} exp_t;

  int          n_vec = 0, n_err = 0, n_gnt = 0, budget = 0;
  bit          gnt_en = 1'b1, rsp_en = 1'b1, err_armed = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] rsp_q[$];
  logic [31:0] exp_addr[$];
  exp_t        exp_rsp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Queue an expected grant address and, if it is not to be dropped, its delivery.
  task automatic exp_fetch(input logic [31:0] addr, input bit dlv, input logic [31:0] pc,
                           input bit err);
    exp_t e;
    exp_addr.push_back(addr);
    if (dlv) begin
      e.instr = err ? 32'h0000_0013 : (addr ^ 32'hA5A5_0000);
      e.pc    = pc;
      e.err   = err;
      exp_rsp.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk_i); #1; end
  endtask

  task automatic drain(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_addr.size() == 0 && exp_rsp.size() == 0 && rsp_q.size() == 0) break;
      step(1);
    end
    n_vec++;
    if (exp_addr.size() != 0 || exp_rsp.size() != 0 || rsp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: drain timeout, %0d grants / %0d deliveries still expected",
               name, exp_addr.size(), exp_rsp.size());
    end
  endtask

  task automatic wait_gnts(input string name, input int n, input int max);
    for (int i = 0; i < max && n_gnt < n; i++) step(1);
    chk(name, n_gnt, n);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; budget = 0; gnt_en = 1'b1; rsp_en = 1'b1; err_armed = 1'b0;
    redirect = 1'b0; rsp_q.delete(); exp_addr.delete(); exp_rsp.delete();
    step(2);
    rstn_i = 1'b1; n_gnt = 0;
    step(1);
  endtask

  // Memory model: in-order responses one cycle after grant, data = addr ^ A5A50000.
  // Also plays the prefetch buffer, requesting until 'budget' grants are seen.
  initial begin
    logic [31:0] a;
    bus.fs_imem_gnt = 1'b0; bus.fs_imem_rvalid = 1'b0; bus.fs_imem_rdata = '0;
`ifdef RISTRETTO_FS_IMEM_ERR_EN
    bus.fs_imem_err = 1'b0;
`endif
    forever begin
      @(negedge clk_i);
      bus.fs_imem_gnt = 1'b0; bus.fs_imem_rvalid = 1'b0;
`ifdef RISTRETTO_FS_IMEM_ERR_EN
      bus.fs_imem_err = 1'b0;
`endif
      if (rsp_en && rsp_q.size() != 0) begin
        a = rsp_q.pop_front();
        bus.fs_imem_rvalid = 1'b1;
        bus.fs_imem_rdata  = a ^ 32'hA5A5_0000;
`ifdef RISTRETTO_FS_IMEM_ERR_EN
        bus.fs_imem_err = err_armed && (a == err_addr);
`endif
      end
      if (rstn_i && bus.fs_imem_req && gnt_en) begin
        bus.fs_imem_gnt = 1'b1;
        rsp_q.push_back(bus.fs_imem_addr);
        n_gnt++;
        if (exp_addr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL imem_addr: unexpected grant of %h", bus.fs_imem_addr);
        end else chk("imem_addr", bus.fs_imem_addr, exp_addr.pop_front());
        if (budget > 0) budget--;
      end
      fetch_req = (budget > 0);
    end
  end

  // Delivery monitor: every new_instr pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rstn_i && new_instr) begin
        if (exp_rsp.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL new_instr: unexpected pulse pc=%h instr=%h", current_pc, instr);
        end else begin
          e = exp_rsp.pop_front();
          chk("instr", instr, e.instr);
          chk("current_pc", current_pc, e.pc);
`ifdef RISTRETTO_FS_IMEM_ERR_EN
          chk("fetch_err", {31'b0, fetch_err}, {31'b0, e.err});
`endif
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(1);
    chk("rst imem_req", {31'b0, bus.fs_imem_req}, 32'd0);
    chk("rst new_instr", {31'b0, new_instr}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst imem_addr", bus.fs_imem_addr, 32'h80);
    chk("rst current_pc", current_pc, 32'h80);
    fetch_en = 1'b0; #1;
    chk("busy when fetch disabled", {31'b0, busy}, 32'd1);
    fetch_en = 1'b1;

    // 1: streaming with gnt tied high
    do_reset();
    exp_fetch(32'h80, 1, 32'h84, 0);
    exp_fetch(32'h84, 1, 32'h88, 0);
    exp_fetch(32'h88, 1, 32'h8C, 0);
    budget = 3;
    drain("t1 stream", 40);

    // 2: grant withheld for three cycles
    do_reset();
    gnt_en = 1'b0;
    exp_fetch(32'h80, 1, 32'h84, 0);
    exp_fetch(32'h84, 1, 32'h88, 0);
    budget = 2;
    for (int i = 0; i < 20 && !bus.fs_imem_req; i++) step(1);
    for (int k = 0; k < 3; k++) begin
      chk("t2 addr held", bus.fs_imem_addr, 32'h80);
      chk("t2 busy", {31'b0, busy}, 32'd1);
      if (k < 2) step(1);
    end
    gnt_en = 1'b1;
    drain("t2 backpressure", 40);

    // 3: outstanding limit with responses withheld
    do_reset();
    rsp_en = 1'b0;
    exp_fetch(32'h80, 1, 32'h84, 0);
    exp_fetch(32'h84, 1, 32'h88, 0);
    exp_fetch(32'h88, 1, 32'h8C, 0);
    budget = 3;
    wait_gnts("t3 two grants", 2, 20);
    step(1);
    for (int k = 0; k < 3; k++) begin
      chk("t3 no req", {31'b0, bus.fs_imem_req}, 32'd0);
      chk("t3 busy", {31'b0, busy}, 32'd1);
      step(1);
    end
    chk("t3 grants capped", n_gnt, 2);
    rsp_en = 1'b1;
    drain("t3 limit", 40);

    // 4: redirect with two responses in flight
    do_reset();
    rsp_en = 1'b0;
    exp_fetch(32'h80, 0, 32'h0, 0);
    exp_fetch(32'h84, 0, 32'h0, 0);
    budget = 2;
    wait_gnts("t4 two grants", 2, 20);
    step(1);
    redirect = 1'b1; redirect_pc = 32'h200;
    step(1);
    redirect = 1'b0;
    chk("t4 busy draining", {31'b0, busy}, 32'd1);
    exp_fetch(32'h200, 1, 32'h204, 0);
    exp_fetch(32'h204, 1, 32'h208, 0);
    budget = 2; rsp_en = 1'b1;
    drain("t4 redirect", 40);

    // 5: redirect on a gnt+rvalid cycle, then a second redirect while draining
    do_reset();
    exp_fetch(32'h80, 0, 32'h0, 0);
    exp_fetch(32'h84, 0, 32'h0, 0);
    budget = 2;
    for (int i = 0; i < 20 && !(bus.fs_imem_gnt && bus.fs_imem_rvalid); i++) step(1);
    chk("t5 gnt+rvalid seen", {30'b0, bus.fs_imem_gnt, bus.fs_imem_rvalid}, 32'd3);
    redirect = 1'b1; redirect_pc = 32'h200; rsp_en = 1'b0;
    step(1);
    redirect = 1'b0;
    step(1);
    chk("t5 busy draining", {31'b0, busy}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h300;
    step(1);
    redirect = 1'b0;
    exp_fetch(32'h300, 1, 32'h304, 0);
    exp_fetch(32'h304, 1, 32'h308, 0);
    budget = 2; rsp_en = 1'b1;
    drain("t5 double redirect", 40);

    // 7: PC wraps from the top of the address space
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect = 1'b0;
    exp_fetch(32'hFFFF_FFFC, 1, 32'h0000_0000, 0);
    exp_fetch(32'h0000_0000, 1, 32'h0000_0004, 0);
    budget = 2;
    drain("t7 wrap", 40);

`ifdef RISTRETTO_FS_IMEM_ERR_EN
    // 6: bus error halts fetching until the next redirect
    do_reset();
    err_addr = 32'h84; err_armed = 1'b1;
    exp_fetch(32'h80, 1, 32'h84, 0);
    exp_fetch(32'h84, 1, 32'h88, 1);
    budget = 2;
    drain("t6 err delivery", 40);
    budget = 2;
    step(4);
    chk("t6 no grants after err", n_gnt, 2);
    chk("t6 busy after err", {31'b0, busy}, 32'd1);
    chk("t6 no req after err", {31'b0, bus.fs_imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h400;
    step(1);
    redirect = 1'b0;
    exp_fetch(32'h400, 1, 32'h404, 0);
    exp_fetch(32'h404, 1, 32'h408, 0);
    drain("t6 resume", 40);
`endif

    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
